countdown_timer: RTL and testbench

Parametrised MM:SS countdown timer controller for the DE-board top level. It is driven by SW[7:0] (BCD entry) and pushbuttons KEY[2:1], and shows minutes:seconds on HEX3..HEX0. Its state is shown on LEDR, and LEDR flashes when the count expires. Tick rate, flash rate and flash duration are parameters, so the same RTL runs on hardware and in fast simulation.

---
 rtl/timer_pkg.sv | 77 +++++++
 rtl/key_edge_sync.sv | 29 ++
 rtl/countdown_timer.sv | 201 ++++++++++++++++++++
 tb/tb_countdown_timer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared state codes, 7-segment constants and BCD helpers for the countdown timer.
package timer_pkg;

  // FSM state codes; the 3-bit value is shown directly on LEDR[2:0].
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSetSec = 3'd1;
  localparam logic [2:0] StSetMin = 3'd2;
  localparam logic [2:0] StStop   = 3'd3;
  localparam logic [2:0] StRun    = 3'd4;
  localparam logic [2:0] StFlash  = 3'd5;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Stored time as four BCD digits mt:mu:st:su.
  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
  } bcd_time_t;

  function automatic logic [6:0] seg7(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] clamp_bcd(input logic [3:0] v, input logic [3:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  // One-second decrement with BCD borrow; 00:00 is left untouched.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t == '0) return t;
    if (t.su != 4'd0) begin
      r.su = t.su - 4'd1;
    end else begin
      r.su = 4'd9;
      if (t.st != 4'd0) begin
        r.st = t.st - 4'd1;
      end else begin
        r.st = 4'd5;
        if (t.mu != 4'd0) begin
          r.mu = t.mu - 4'd1;
        end else begin
          r.mu = 4'd9;
          r.mt = t.mt - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchroniser for an active-low pushbutton plus falling-edge detector.
module key_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  logic sync1_q, sync2_q, prev_q;

  // Synchronise the button and keep the previous synchronised level; idle level is released (1).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // One-cycle pulse on the 1->0 transition of the synchronised level.
  always_comb begin
    press_o = prev_q & ~sync2_q;
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer: BCD entry from SW, set/start keys, 7-segment display, LEDR status/flash.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_CYCLES  = 50_000_000,
  parameter int unsigned FLASH_CYCLES = 12_500_000,
  parameter int unsigned FLASH_LIMIT  = 0
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] SW,
  input  logic [2:0] KEY,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  localparam int unsigned TickW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned FlashW  = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam int unsigned ToggleW = (FLASH_LIMIT > 0) ? $clog2(FLASH_LIMIT + 1) : 1;

  // KEY[0] is the board reset and is consumed outside this block.
  logic unused_key0;
  assign unused_key0 = KEY[0];

  logic press_set, press_start;

  key_edge_sync u_key_set (
    .clk_i   (CLOCK_50),
    .rst_ni  (reset),
    .key_ni  (KEY[1]),
    .press_o (press_set)
  );

  key_edge_sync u_key_start (
    .clk_i   (CLOCK_50),
    .rst_ni  (reset),
    .key_ni  (KEY[2]),
    .press_o (press_start)
  );

  logic [2:0]         state_q, state_d;
  bcd_time_t          time_q, time_d;
  logic [TickW-1:0]   presc_q, presc_d;
  logic [FlashW-1:0]  flash_cnt_q, flash_cnt_d;
  logic               phase_q, phase_d;
  logic [ToggleW-1:0] toggles_q, toggles_d;
  logic [9:0]         ledr_q, ledr_d;
  logic [6:0]         hex0_q, hex1_q, hex2_q, hex3_q;
  logic [6:0]         hex0_d, hex1_d, hex2_d, hex3_d;

  logic [3:0] sw_tens, sw_units;
  logic       tick, flash_wrap, limit_hit;
  bcd_time_t  time_dec;

  // Clamp the switch entry and derive counter events.
  always_comb begin
    sw_tens    = clamp_bcd(SW[7:4], 4'd5);
    sw_units   = clamp_bcd(SW[3:0], 4'd9);
    tick       = (presc_q == TickW'(TICK_CYCLES - 1));
    flash_wrap = (flash_cnt_q == FlashW'(FLASH_CYCLES - 1));
    limit_hit  = (FLASH_LIMIT > 0) && flash_wrap &&
                 ((32'(toggles_q) + 32'd1) == FLASH_LIMIT);
    time_dec   = bcd_dec(time_q);
  end

  // FSM, BCD time, prescaler and flash counter next state.
  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    presc_d     = '0;
    flash_cnt_d = '0;
    phase_d     = phase_q;
    toggles_d   = toggles_q;

    case (state_q)
      StIdle: begin
        if (press_set) state_d = StSetSec;
      end
      StSetSec: begin
        if (press_set) begin
          time_d.st = sw_tens;
          time_d.su = sw_units;
          state_d   = StSetMin;
        end
      end
      StSetMin: begin
        if (press_set) begin
          time_d.mt = sw_tens;
          time_d.mu = sw_units;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (press_start) begin
          if (time_q != '0) state_d = StRun;
        end else if (press_set) begin
          state_d = StSetSec;
        end
      end
      StRun: begin
        if (tick && (time_q != '0)) begin
          time_d = time_dec;
          // The final tick beats a simultaneous stop request.
          if (time_dec == '0) begin
            state_d   = StFlash;
            phase_d   = 1'b1;
            toggles_d = '0;
          end else if (press_start) begin
            state_d = StStop;
          end
        end else if (press_start) begin
          state_d = StStop;
        end
        if (state_d == StRun) presc_d = tick ? '0 : presc_q + TickW'(1);
      end
      StFlash: begin
        if (flash_wrap) begin
          phase_d   = ~phase_q;
          toggles_d = toggles_q + ToggleW'(1);
        end
        if (press_set || press_start || limit_hit) begin
          state_d = StIdle;
          time_d  = '0;
        end else begin
          flash_cnt_d = flash_wrap ? '0 : flash_cnt_q + FlashW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered display and LED values, derived from the current state and time.
  always_comb begin
    logic [3:0] d3, d2, d1, d0;
    d3 = time_q.mt;
    d2 = time_q.mu;
    d1 = time_q.st;
    d0 = time_q.su;
    if (state_q == StSetSec) begin
      d1 = sw_tens;
      d0 = sw_units;
    end
    if (state_q == StSetMin) begin
      d3 = sw_tens;
      d2 = sw_units;
    end
    hex3_d = seg7(d3);
    hex2_d = seg7(d2);
    hex1_d = seg7(d1);
    hex0_d = seg7(d0);
    ledr_d = (state_q == StFlash) ? {10{phase_q}} : {7'b0, state_q};
  end

  // State and datapath registers.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      time_q      <= '0;
      presc_q     <= '0;
      flash_cnt_q <= '0;
      phase_q     <= 1'b0;
      toggles_q   <= '0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      presc_q     <= presc_d;
      flash_cnt_q <= flash_cnt_d;
      phase_q     <= phase_d;
      toggles_q   <= toggles_d;
    end
  end

  // Output registers.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ledr_q <= '0;
      hex0_q <= SEG_0;
      hex1_q <= SEG_0;
      hex2_q <= SEG_0;
      hex3_q <= SEG_0;
    end else begin
      ledr_q <= ledr_d;
      hex0_q <= hex0_d;
      hex1_q <= hex1_d;
      hex2_q <= hex2_d;
      hex3_q <= hex3_d;
    end
  end

  assign LEDR = ledr_q;
  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;
  assign HEX2 = hex2_q;
  assign HEX3 = hex3_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (FLASH_LIMIT 3 and 0) against a seconds-based model.
module tb_countdown_timer;

  localparam int TC = 4;
  localparam int FC = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] SW;
  logic [2:0] KEY;
  logic [9:0] ledr_a, ledr_b;
  logic [6:0] hex0_a, hex1_a, hex2_a, hex3_a;
  logic [6:0] hex0_b, hex1_b, hex2_b, hex3_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  countdown_timer #(.TICK_CYCLES(TC), .FLASH_CYCLES(FC), .FLASH_LIMIT(3)) dut_a (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .SW       (SW),
    .KEY      (KEY),
    .LEDR     (ledr_a),
    .HEX0     (hex0_a),
    .HEX1     (hex1_a),
    .HEX2     (hex2_a),
    .HEX3     (hex3_a)
  );

  countdown_timer #(.TICK_CYCLES(TC), .FLASH_CYCLES(FC), .FLASH_LIMIT(0)) dut_b (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .SW       (SW),
    .KEY      (KEY),
    .LEDR     (ledr_b),
    .HEX0     (hex0_b),
    .HEX1     (hex1_b),
    .HEX2     (hex2_b),
    .HEX3     (hex3_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'h40;
      1:       return 7'h79;
      2:       return 7'h24;
      3:       return 7'h30;
      4:       return 7'h19;
      5:       return 7'h12;
      6:       return 7'h02;
      7:       return 7'h78;
      8:       return 7'h00;
      9:       return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference model: time kept as total seconds, modes 0..5, cycle counters since mode entry.
  int         m_mode [2];
  int         m_secs [2];
  int         m_run  [2];
  int         m_age  [2];
  logic [9:0] e_ledr [2];
  logic [6:0] e_hex  [2][4];
  logic [2:0] kh1, kh2, kh3;

  task automatic model_step(input int i, input int lim, input bit p1, input bit p2,
                            input int ct, input int cu);
    int mins, secs;
    int dig[4];
    mins = m_secs[i] / 60;
    secs = m_secs[i] % 60;
    dig[3] = mins / 10;
    dig[2] = mins % 10;
    dig[1] = secs / 10;
    dig[0] = secs % 10;
    if (m_mode[i] == 1) begin dig[1] = ct; dig[0] = cu; end
    if (m_mode[i] == 2) begin dig[3] = ct; dig[2] = cu; end
    if (m_mode[i] == 5) e_ledr[i] = (((m_age[i] / FC) % 2) == 0) ? 10'h3FF : 10'h000;
    else                e_ledr[i] = 10'(m_mode[i]);
    for (int k = 0; k < 4; k++) e_hex[i][k] = seg_of(dig[k]);

    case (m_mode[i])
      0: if (p1) m_mode[i] = 1;
      1: if (p1) begin m_secs[i] = mins * 60 + ct * 10 + cu; m_mode[i] = 2; end
      2: if (p1) begin m_secs[i] = (ct * 10 + cu) * 60 + secs; m_mode[i] = 3; end
      3: begin
        if (p2) begin
          if (m_secs[i] != 0) begin m_mode[i] = 4; m_run[i] = 0; end
        end else if (p1) begin
          m_mode[i] = 1;
        end
      end
      4: begin
        if (((m_run[i] + 1) % TC) == 0) begin
          if (m_secs[i] > 0) m_secs[i] = m_secs[i] - 1;
          if (m_secs[i] == 0) begin m_mode[i] = 5; m_age[i] = 0; end
          else if (p2) m_mode[i] = 3;
        end else if (p2) begin
          m_mode[i] = 3;
        end
        m_run[i] = m_run[i] + 1;
      end
      5: begin
        if (p1 || p2 || (lim > 0 && (m_age[i] + 1) == lim * FC)) begin
          m_mode[i] = 0;
          m_secs[i] = 0;
        end
        m_age[i] = m_age[i] + 1;
      end
      default: m_mode[i] = 0;
    endcase
  endtask

  always @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0;
        m_secs[i] = 0;
        m_run[i]  = 0;
        m_age[i]  = 0;
        e_ledr[i] = 10'h000;
        for (int k = 0; k < 4; k++) e_hex[i][k] = 7'h40;
      end
      kh1 = 3'b111;
      kh2 = 3'b111;
      kh3 = 3'b111;
    end else begin
      bit p1, p2;
      int ct, cu;
      p1 = kh3[1] & ~kh2[1];
      p2 = kh3[2] & ~kh2[2];
      ct = (SW[7:4] > 4'd5) ? 5 : int'(SW[7:4]);
      cu = (SW[3:0] > 4'd9) ? 9 : int'(SW[3:0]);
      model_step(0, 3, p1, p2, ct, cu);
      model_step(1, 0, p1, p2, ct, cu);
      kh3 = kh2;
      kh2 = kh1;
      kh1 = KEY;
    end
  end

  // Continuous comparison away from the active edge.
  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      check("a.LEDR", 32'(ledr_a), 32'(e_ledr[0]));
      check("a.HEX0", 32'(hex0_a), 32'(e_hex[0][0]));
      check("a.HEX1", 32'(hex1_a), 32'(e_hex[0][1]));
      check("a.HEX2", 32'(hex2_a), 32'(e_hex[0][2]));
      check("a.HEX3", 32'(hex3_a), 32'(e_hex[0][3]));
      check("b.LEDR", 32'(ledr_b), 32'(e_ledr[1]));
      check("b.HEX0", 32'(hex0_b), 32'(e_hex[1][0]));
      check("b.HEX1", 32'(hex1_b), 32'(e_hex[1][1]));
      check("b.HEX2", 32'(hex2_b), 32'(e_hex[1][2]));
      check("b.HEX3", 32'(hex3_b), 32'(e_hex[1][3]));
    end
  end

  // m[0] presses KEY[1], m[1] presses KEY[2]; held low two cycles then released.
  task automatic press(input logic [1:0] m);
    KEY[1] = ~m[0];
    KEY[2] = ~m[1];
    repeat (2) @(negedge CLOCK_50);
    KEY = 3'b111;
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic sync_reset();
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    SW    = 8'h00;
    KEY   = 3'b111;
    cycles(2);
    check("rst_ledr", 32'(ledr_a), 32'h0);
    check("rst_hex0", 32'(hex0_a), 32'h40);
    check("rst_hex3", 32'(hex3_b), 32'h40);
    reset  = 1'b1;
    chk_en = 1'b1;

    // Entry with clamping: 7C -> 5:9 seconds, then 02 minutes.
    press(2'b01);
    SW = 8'h7C;
    cycles(2);
    press(2'b01);
    check("clamp_st", 32'(hex1_a), 32'h12);
    check("clamp_su", 32'(hex0_a), 32'h10);
    SW = 8'h02;
    press(2'b01);
    check("stop_ledr", 32'(ledr_a), 32'h3);
    check("stop_mu", 32'(hex2_a), 32'h24);
    check("stop_mt", 32'(hex3_a), 32'h40);

    // Load 01:00 and run it down through the full borrow chain.
    press(2'b01);
    SW = 8'h00;
    press(2'b01);
    SW = 8'h01;
    press(2'b01);
    check("load_mu", 32'(hex2_b), 32'h79);
    press(2'b10);
    cycles(2);
    check("first_dec_st", 32'(hex1_a), 32'h12);
    check("first_dec_su", 32'(hex0_a), 32'h10);
    check("first_dec_mu", 32'(hex2_a), 32'h40);
    cycles(236);
    check("flash_a", 32'(ledr_a), 32'h3FF);
    check("flash_b", 32'(ledr_b), 32'h3FF);
    check("flash_hex0", 32'(hex0_b), 32'h40);
    cycles(10);
    check("limit_idle", 32'(ledr_a), 32'h0);
    press(2'b01);
    check("key_exit_b", 32'(ledr_b), 32'h0);
    check("setsec_a", 32'(ledr_a), 32'h1);

    // Start attempt at 00:00 stays in STOP.
    sync_reset();
    press(2'b01);
    SW = 8'h00;
    press(2'b01);
    press(2'b01);
    press(2'b10);
    cycles(2);
    check("zero_start_a", 32'(ledr_a), 32'h3);
    check("zero_start_b", 32'(ledr_b), 32'h3);

    // Reset asserted mid-RUN clears outputs immediately.
    press(2'b01);
    SW = 8'h05;
    press(2'b01);
    SW = 8'h00;
    press(2'b01);
    press(2'b10);
    cycles(3);
    @(posedge CLOCK_50);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_ledr", 32'(ledr_a), 32'h0);
    check("async_rst_hex0", 32'(hex0_a), 32'h40);
    @(negedge CLOCK_50);
    reset = 1'b1;

    // Randomised key/switch activity with occasional asynchronous resets.
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(posedge CLOCK_50);
        #($urandom_range(1, 4));
        reset = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) SW = 8'($urandom);
      else                           SW = {4'h0, 4'($urandom_range(0, 3))};
      case ($urandom_range(0, 4))
        0:       press(2'b01);
        1:       press(2'b10);
        2:       press(2'b11);
        default: cycles(($urandom_range(0, 3) == 0) ? $urandom_range(10, 60)
                                                     : $urandom_range(1, 6));
      endcase
    end

    cycles(4);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
